// File: rtl/axi_rd_master.sv
// AXI read-burst initiator: one AR burst per user request, each R beat returned as a registered strobe.
// Define AXI_RD_LAST_CHECK_EN to flag rlast/beat-count disagreement on rd_err.
module axi_rd_master #(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DATA_WIDTH = 16,
  parameter logic [7:0]  RBURST_LEN = 8'd8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_end,
  input  logic                  rd_trig,
  input  logic [7:0]            rd_len,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_data_en,
  output logic                  rd_done,
  output logic                  rd_err,
  output logic                  axi_arvalid,
  input  logic                  axi_arready,
  output logic [ADDR_WIDTH-1:0] axi_araddr,
  output logic [7:0]            axi_arlen,
  input  logic                  axi_rvalid,
  output logic                  axi_rready,
  input  logic                  axi_rlast,
  input  logic [DATA_WIDTH-1:0] axi_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_AR   = 2'd1,
    S_R    = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic                    idle_q, idle_d;
  logic [7:0]              len_q, len_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [7:0]              arlen_q, arlen_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    arvalid_q, arvalid_d;
  logic                    rready_q, rready_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    data_en_q, data_en_d;
  logic                    done_q, done_d;
  logic                    err_q, err_d;

  logic                    accept_s;
  logic                    ar_fire_s;
  logic                    r_fire_s;
  logic                    final_cnt_s;
  logic [7:0]              clamp_len_s;

  // idle_q is a registered copy of "in IDLE", so rd_ready stays low during and right after reset
  assign rd_ready    = idle_q & init_end;
  assign accept_s    = rd_trig & rd_ready;
  assign ar_fire_s   = arvalid_q & axi_arready;
  assign r_fire_s    = rready_q & axi_rvalid;
  assign final_cnt_s = (cnt_q == (len_q - 8'd1));
  assign clamp_len_s = (rd_len > RBURST_LEN) ? RBURST_LEN : rd_len;

`ifndef AXI_RD_LAST_CHECK_EN
  logic unused_rlast_s;
  assign unused_rlast_s = axi_rlast;
`endif

  // Next-state and next-output logic
  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    arlen_d   = arlen_q;
    addr_d    = addr_q;
    data_d    = data_q;
    data_en_d = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          addr_d  = rd_addr;
          len_d   = clamp_len_s;
          cnt_d   = 8'd0;
          arlen_d = (clamp_len_s == 8'd0) ? 8'd0 : (clamp_len_s - 8'd1);
          state_d = (clamp_len_s == 8'd0) ? S_DONE : S_AR;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_AR: begin
        if (ar_fire_s) begin
          state_d = S_R;
        end else begin
          state_d = S_AR;
        end
      end
      S_R: begin
        if (r_fire_s) begin
          data_d    = axi_rdata;
          data_en_d = 1'b1;
          cnt_d     = cnt_q + 8'd1;
`ifdef AXI_RD_LAST_CHECK_EN
          err_d     = axi_rlast ^ final_cnt_s;
`else
          err_d     = 1'b0;
`endif
          // termination is count-based; rlast only feeds the optional check
          state_d   = final_cnt_s ? S_DONE : S_R;
        end else begin
          state_d = S_R;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    idle_d    = (state_d == S_IDLE);
    arvalid_d = (state_d == S_AR);
    rready_d  = (state_d == S_R);
    done_d    = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idle_q    <= 1'b0;
      len_q     <= 8'd0;
      cnt_q     <= 8'd0;
      arlen_q   <= 8'd0;
      addr_q    <= '0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      data_q    <= '0;
      data_en_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      idle_q    <= idle_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      arlen_q   <= arlen_d;
      addr_q    <= addr_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      data_q    <= data_d;
      data_en_q <= data_en_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign rd_data     = data_q;
  assign rd_data_en  = data_en_q;
  assign rd_done     = done_q;
  assign rd_err      = err_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = addr_q;
  assign axi_arlen   = arlen_q;
  assign axi_rready  = rready_q;

endmodule

// File: tb/tb_axi_rd_master.sv
// Self-checking bench for axi_rd_master: transaction-level reference model plus randomized AXI slave.
module tb_axi_rd_master;

  logic        clk = 1'b0;
  logic        rst;
  logic        init_end;
  logic        rd_trig;
  logic [7:0]  rd_len;
  logic [26:0] rd_addr;
  logic        rd_ready;
  logic [15:0] rd_data;
  logic        rd_data_en;
  logic        rd_done;
  logic        rd_err;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [26:0] axi_araddr;
  logic [7:0]  axi_arlen;
  logic        axi_rvalid;
  logic        axi_rready;
  logic        axi_rlast;
  logic [15:0] axi_rdata;

  axi_rd_master dut (
    .clk(clk), .rst(rst), .init_end(init_end), .rd_trig(rd_trig),
    .rd_len(rd_len), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rd_data(rd_data), .rd_data_en(rd_data_en), .rd_done(rd_done), .rd_err(rd_err),
    .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_araddr(axi_araddr),
    .axi_arlen(axi_arlen), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .axi_rlast(axi_rlast), .axi_rdata(axi_rdata)
  );

  always #5 clk = ~clk;

`ifdef AXI_RD_LAST_CHECK_EN
  localparam bit LAST_CHK = 1'b1;
`else
  localparam bit LAST_CHK = 1'b0;
`endif

  int n_vec = 0;
  int n_err = 0;

  // reference model: burst bookkeeping in terms of outstanding work
  bit          m_idle, m_ar_pend, m_rbusy, m_done, m_en, m_err;
  int          m_left, m_len;
  logic [15:0] m_data;
  logic [26:0] m_addr;

  // what happened at the edge just crossed (from the model's view of the handshakes)
  bit          p_rst, p_acc, p_arf, p_rf, p_rlast;
  logic [15:0] p_rdata;
  int          p_len;
  logic [26:0] p_addr;

  // slave behaviour knobs
  int ar_delay, ar_wait, r_prob, bi, extra_last;
  bit toggle_mode, tog, dmode;

  // observed statistics for literal checks
  logic [15:0] strobe_q[$];
  int ar_cycles, err_cnt, err_idx, done_cnt, done_strobes;
  bit done_en;
  logic [7:0] seen_arlen;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_idle = 0; m_ar_pend = 0; m_rbusy = 0; m_done = 0; m_en = 0; m_err = 0;
    m_left = 0; m_len = 0; m_data = 16'd0; m_addr = 27'd0;
  endtask

  task automatic clear_stats();
    strobe_q.delete();
    ar_cycles = 0; err_cnt = 0; err_idx = 0; done_cnt = 0; done_strobes = 0;
    done_en = 0; seen_arlen = 8'd0;
  endtask

  task automatic model_update();
    if (p_rst) begin
      model_reset();
    end else begin
      m_en = p_rf;
      if (p_rf) m_data = p_rdata;
      m_err  = LAST_CHK && p_rf && (p_rlast != (m_left == 1));
      m_done = (p_rf && m_left == 1) || (p_acc && p_len == 0);
      if (p_rf) m_left--;
      if (p_acc) begin
        m_addr = p_addr; m_len = p_len; m_left = p_len;
      end
      m_rbusy   = p_arf || (m_rbusy && m_left != 0);
      m_ar_pend = (p_acc && p_len != 0) || (m_ar_pend && !p_arf);
      m_idle    = !m_ar_pend && !m_rbusy && !m_done;
    end
  endtask

  task automatic compare_all();
    chk("rd_ready",   {31'd0, rd_ready},    {31'd0, m_idle & init_end});
    chk("arvalid",    {31'd0, axi_arvalid}, {31'd0, m_ar_pend});
    chk("rready",     {31'd0, axi_rready},  {31'd0, m_rbusy});
    chk("rd_data_en", {31'd0, rd_data_en},  {31'd0, m_en});
    chk("rd_done",    {31'd0, rd_done},     {31'd0, m_done});
    chk("rd_err",     {31'd0, rd_err},      {31'd0, m_err});
    if (m_en) chk("rd_data", {16'd0, rd_data}, {16'd0, m_data});
    if (m_ar_pend) begin
      chk("araddr", {5'd0, axi_araddr}, {5'd0, m_addr});
      chk("arlen",  {24'd0, axi_arlen}, 32'(m_len - 1));
    end
    if (axi_arvalid) begin ar_cycles++; seen_arlen = axi_arlen; end
    if (rd_data_en) strobe_q.push_back(rd_data);
    if (rd_err) begin err_cnt++; err_idx = strobe_q.size(); end
    if (rd_done) begin done_cnt++; done_en = rd_data_en; done_strobes = strobe_q.size(); end
  endtask

  task automatic slave_drive();
    if (axi_arvalid) begin
      ar_wait++;
      axi_arready = (ar_wait > ar_delay);
    end else begin
      ar_wait = 0;
      axi_arready = 1'($urandom_range(0, 1));
    end
    if (axi_rready) begin
      if (toggle_mode) begin tog = !tog; axi_rvalid = tog; end
      else axi_rvalid = ($urandom_range(0, 99) < r_prob);
      axi_rdata = dmode ? 16'(bi + 1) : 16'($urandom);
      axi_rlast = axi_rvalid && ((bi == m_len - 1) || (bi == extra_last));
    end else begin
      bi = 0; tog = 0;
      axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = 16'd0;
    end
  endtask

  // one clock: drive slave, note the handshakes the edge will see, cross it, predict and compare
  task automatic step();
    bit s_fire;
    slave_drive();
    #1;
    p_rst   = rst;
    p_acc   = rd_trig && m_idle && init_end;
    p_arf   = m_ar_pend && axi_arready;
    p_rf    = m_rbusy && axi_rvalid;
    p_rdata = axi_rdata;
    p_rlast = axi_rlast;
    p_len   = (rd_len > 8'd8) ? 8 : int'(rd_len);
    p_addr  = rd_addr;
    s_fire  = axi_rvalid && axi_rready;
    @(negedge clk);
    if (s_fire) bi++;
    model_update();
    compare_all();
  endtask

  task automatic request(input logic [26:0] a, input logic [7:0] l);
    int b;
    rd_addr = a; rd_len = l; rd_trig = 1'b1;
    b = 0;
    do begin step(); b++; end while (!p_acc && b < 400);
    if (!p_acc) chk("accept_timeout", 32'd0, 32'd1);
    rd_trig = 1'b0;
  endtask

  task automatic wait_done(input bit rand_init);
    int b;
    b = 0;
    while (!m_done && b < 400) begin
      if (rand_init) init_end = ($urandom_range(0, 4) != 0);
      step(); b++;
    end
    if (!m_done) chk("done_timeout", 32'd0, 32'd1);
    init_end = 1'b1;
    step();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"},  {31'd0, rd_ready},    32'd0);
    chk({tag, "_en"},     {31'd0, rd_data_en},  32'd0);
    chk({tag, "_done"},   {31'd0, rd_done},     32'd0);
    chk({tag, "_err"},    {31'd0, rd_err},      32'd0);
    chk({tag, "_arv"},    {31'd0, axi_arvalid}, 32'd0);
    chk({tag, "_rrdy"},   {31'd0, axi_rready},  32'd0);
    chk({tag, "_data"},   {16'd0, rd_data},     32'd0);
    chk({tag, "_araddr"}, {5'd0, axi_araddr},   32'd0);
    chk({tag, "_arlen"},  {24'd0, axi_arlen},   32'd0);
  endtask

  task automatic slave_cfg(input int ard, input int rp, input bit tm, input bit dm, input int ex);
    ar_delay = ard; r_prob = rp; toggle_mode = tm; dmode = dm; extra_last = ex;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; init_end = 1'b0; rd_trig = 1'b0; rd_len = 8'd0; rd_addr = 27'd0;
    axi_arready = 1'b0; axi_rvalid = 1'b0; axi_rlast = 1'b0; axi_rdata = 16'd0;
    ar_wait = 0; bi = 0; tog = 0;
    slave_cfg(0, 100, 0, 1, -1);
    model_reset();
    clear_stats();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;
    step();
    init_end = 1'b1;
    step();

    // test 1: 8 beats, arready after 3 cycles
    clear_stats(); slave_cfg(3, 100, 0, 1, -1);
    request(27'h10, 8'd8); wait_done(0);
    chk("t1_strobes", 32'(strobe_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < strobe_q.size(); i++) chk("t1_data", {16'd0, strobe_q[i]}, 32'(i + 1));
    chk("t1_ar_cycles", 32'(ar_cycles), 32'd4);
    chk("t1_arlen", {24'd0, seen_arlen}, 32'd7);
    chk("t1_done_cnt", 32'(done_cnt), 32'd1);
    chk("t1_done_with_8th", {31'd0, done_en}, 32'd1);
    chk("t1_done_strobes", 32'(done_strobes), 32'd8);
    chk("t1_err", 32'(err_cnt), 32'd0);

    // test 2: rvalid toggling
    clear_stats(); slave_cfg(0, 100, 1, 1, -1);
    request(27'h40, 8'd8); wait_done(0);
    chk("t2_strobes", 32'(strobe_q.size()), 32'd8);
    for (int i = 0; i < 8 && i < strobe_q.size(); i++) chk("t2_data", {16'd0, strobe_q[i]}, 32'(i + 1));

    // test 3: clamp 20 -> 8
    clear_stats(); slave_cfg(1, 100, 0, 1, -1);
    request(27'h200, 8'd20); wait_done(0);
    chk("t3_arlen", {24'd0, seen_arlen}, 32'd7);
    chk("t3_strobes", 32'(strobe_q.size()), 32'd8);
    chk("t3_done_strobes", 32'(done_strobes), 32'd8);

    // test 4: zero length
    clear_stats();
    request(27'h300, 8'd0);
    chk("t4_done", {31'd0, rd_done}, 32'd1);
    step();
    chk("t4_ready", {31'd0, rd_ready}, 32'd1);
    chk("t4_ar_cycles", 32'(ar_cycles), 32'd0);

    // test 5: rlast early on beat 5 (and on beat 8)
    clear_stats(); slave_cfg(0, 100, 0, 1, 4);
    request(27'h80, 8'd8); wait_done(0);
    chk("t5_strobes", 32'(strobe_q.size()), 32'd8);
    chk("t5_done_cnt", 32'(done_cnt), 32'd1);
    chk("t5_err_cnt", 32'(err_cnt), LAST_CHK ? 32'd1 : 32'd0);
    if (LAST_CHK) chk("t5_err_idx", 32'(err_idx), 32'd5);

    // test 6: init_end low blocks, then reset mid-R at beat 3
    clear_stats(); slave_cfg(0, 100, 0, 1, -1);
    init_end = 1'b0; rd_trig = 1'b1; rd_len = 8'd8; rd_addr = 27'h123;
    repeat (5) step();
    chk("t6_ready_low", {31'd0, rd_ready}, 32'd0);
    chk("t6_no_ar", 32'(ar_cycles), 32'd0);
    init_end = 1'b1;
    begin
      int b;
      b = 0;
      do begin step(); b++; end while (!p_acc && b < 50);
      rd_trig = 1'b0;
      b = 0;
      while (m_left != 5 && b < 100) begin step(); b++; end
      chk("t6_reach_beat3", 32'(m_left), 32'd5);
    end
    done_cnt = 0;
    rst = 1'b1;
    #1;
    chk_zero("t6_async");
    model_reset();
    repeat (2) step();
    rst = 1'b0;
    repeat (3) step();
    chk("t6_no_done", 32'(done_cnt), 32'd0);
    clear_stats();
    request(27'h140, 8'd8); wait_done(0);
    chk("t6_post_strobes", 32'(strobe_q.size()), 32'd8);
    chk("t6_post_done", 32'(done_cnt), 32'd1);

    // randomized bursts
    for (int k = 0; k < 40; k++) begin
      bit hold;
      int ex;
      ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 7)) : -1;
      slave_cfg(int'($urandom_range(0, 3)), int'($urandom_range(30, 100)),
                1'($urandom_range(0, 1)), 1'b0, ex);
      hold = 1'($urandom_range(0, 3) == 0);
      request(27'($urandom), ($urandom_range(0, 9) == 0) ? 8'd255 : 8'($urandom_range(0, 20)));
      rd_trig = hold;
      wait_done(1);
      rd_trig = 1'b0;
    end
    repeat (40) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
